// File: rtl/gun_pkg.sv
// Shared types and default timing constants for the gun heat controller slice.
package gun_pkg;

  typedef enum logic {
    READY   = 1'b0,
    LOCKOUT = 1'b1
  } gun_state_t;

  localparam int unsigned F_CLK   = 50_000_000;
  localparam int unsigned ONE_SEC = F_CLK;
  localparam int unsigned TWO_SEC = 2 * F_CLK;

endpackage

// File: rtl/tick_timer.sv
// Free-running reloadable down-counter; tick is high on the cycle the count is zero.
module tick_timer #(
  parameter int unsigned WIDTH  = 28,
  parameter int unsigned PERIOD = 100_000_000
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam logic [WIDTH-1:0] RELOAD = WIDTH'(PERIOD - 1);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)            count <= RELOAD;
    else if (count == '0) count <= RELOAD;
    else                  count <= count - 1'b1;
  end

  assign tick = (count == '0);

endmodule

// File: rtl/gun_heat_controller.sv
// Rate-limited fire gating with per-shot heat, timed cooling and overheat lockout.
module gun_heat_controller
  import gun_pkg::*;
#(
  parameter int unsigned HEAT_W        = 4,
  parameter int unsigned FIRE_DIV      = ONE_SEC,
  parameter int unsigned COOL_DIV      = TWO_SEC,
  parameter int unsigned DIV_W         = 28,
  parameter int unsigned RECOVER_LEVEL = 3,
  parameter int unsigned WARN_LEVEL    = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              shoot,
  output logic [HEAT_W-1:0] heat,
  output logic              fire_pulse,
  output logic              overheated,
  output logic              warn
);

  localparam logic [HEAT_W-1:0] MAX_HEAT    = '1;
  localparam logic [HEAT_W-1:0] RECOVER     = HEAT_W'(RECOVER_LEVEL);
  localparam logic [DIV_W-1:0]  FIRE_RELOAD = DIV_W'(FIRE_DIV - 1);

  gun_state_t        state, state_n;
  logic [DIV_W-1:0]  fire_cnt;
  logic [HEAT_W-1:0] heat_n;
  logic              cool_tick;
  logic              shot_ok;

  tick_timer #(
    .WIDTH  (DIV_W),
    .PERIOD (COOL_DIV)
  ) u_cool_timer (
    .clock (clock),
    .reset (reset),
    .tick  (cool_tick)
  );

  assign shot_ok = (state == READY) && shoot && (fire_cnt == '0);

  always_comb begin
    state_n = state;
    heat_n  = heat;
    case (state)
      READY: begin
        if (shot_ok) begin
          if (heat != MAX_HEAT) heat_n = heat + 1'b1;
          if (heat_n == MAX_HEAT) state_n = LOCKOUT;
        end else if (cool_tick && !shoot && heat != '0) begin
          heat_n = heat - 1'b1;
        end
      end
      LOCKOUT: begin
        if (cool_tick && heat != '0) begin
          heat_n = heat - 1'b1;
          if (heat_n <= RECOVER) state_n = READY;
        end
      end
      default: state_n = READY;
    endcase
  end

  // Rate limiter runs in every state so it is already armed when lockout ends.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)               fire_cnt <= '0;
    else if (shot_ok)        fire_cnt <= FIRE_RELOAD;
    else if (fire_cnt != '0) fire_cnt <= fire_cnt - 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= READY;
      heat       <= '0;
      fire_pulse <= 1'b0;
      overheated <= 1'b0;
      warn       <= 1'b0;
    end else begin
      state      <= state_n;
      heat       <= heat_n;
      fire_pulse <= shot_ok;
      overheated <= (state_n == LOCKOUT);
      warn       <= (32'(heat_n) >= WARN_LEVEL);
    end
  end

endmodule

// File: tb/tb_gun_heat_controller.sv
// Randomized and scenario-driven bench comparing the controller against a cycle-count model.
module tb_gun_heat_controller;

  localparam int unsigned HEAT_W   = 3;
  localparam int unsigned FIRE_DIV = 4;
  localparam int unsigned COOL_DIV = 8;
  localparam int unsigned RECOVER  = 2;
  localparam int unsigned WARN     = 5;
  localparam int          MAXH     = 7;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              shoot = 1'b0;
  logic [HEAT_W-1:0] heat;
  logic              fire_pulse;
  logic              overheated;
  logic              warn;

  int checks = 0;
  int errors = 0;

  // Reference state: edges since reset release, earliest edge a shot may land on.
  int m_k, m_next_ok, m_heat, m_pulse;
  bit m_locked;

  gun_heat_controller #(
    .HEAT_W        (HEAT_W),
    .FIRE_DIV      (FIRE_DIV),
    .COOL_DIV      (COOL_DIV),
    .DIV_W         (4),
    .RECOVER_LEVEL (RECOVER),
    .WARN_LEVEL    (WARN)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .shoot      (shoot),
    .heat       (heat),
    .fire_pulse (fire_pulse),
    .overheated (overheated),
    .warn       (warn)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_k = 0; m_next_ok = 1; m_heat = 0; m_pulse = 0; m_locked = 0;
  endtask

  task automatic model_edge(input bit s);
    bit tick;
    m_k++;
    tick    = (m_k % COOL_DIV) == 0;
    m_pulse = 0;
    if (!m_locked) begin
      if (s && m_k >= m_next_ok) begin
        m_pulse   = 1;
        m_next_ok = m_k + FIRE_DIV;
        if (m_heat < MAXH) m_heat++;
        if (m_heat == MAXH) m_locked = 1;
      end else if (tick && !s && m_heat > 0) begin
        m_heat--;
      end
    end else if (tick && m_heat > 0) begin
      m_heat--;
      if (m_heat <= RECOVER) m_locked = 0;
    end
  endtask

  task automatic step(input bit s);
    shoot = s;
    @(posedge clock);
    model_edge(s);
    #1;
    chk("heat", int'(heat), m_heat);
    chk("fire_pulse", int'(fire_pulse), m_pulse);
    chk("overheated", int'(overheated), int'(m_locked));
    chk("warn", int'(warn), int'(m_heat >= WARN));
  endtask

  // Asserted mid-cycle; outputs must clear before any clock edge arrives.
  task automatic do_reset();
    reset = 1'b1;
    #2;
    chk("rst_heat", int'(heat), 0);
    chk("rst_fire_pulse", int'(fire_pulse), 0);
    chk("rst_overheated", int'(overheated), 0);
    chk("rst_warn", int'(warn), 0);
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int guard;
    int p;
    model_reset();
    #1;
    do_reset();

    // Idle: heat stays pinned at zero through several cool ticks.
    repeat (30) step(1'b0);

    // Held fire into lockout, then cool down and recover while still held.
    do_reset();
    repeat (75) step(1'b1);

    // Release and cool to zero.
    repeat (50) step(1'b0);

    // Alternating fire requests.
    do_reset();
    for (int i = 0; i < 20; i++) step(i % 2 == 0);
    repeat (40) step(1'b0);

    // Preload heat to 4 then let it drain.
    do_reset();
    repeat (13) step(1'b1);
    chk("preload_heat", int'(heat), 4);
    repeat (40) step(1'b0);

    // Reset in the middle of lockout at heat 6.
    do_reset();
    guard = 0;
    while (!(m_locked && m_heat == 6) && guard < 200) begin
      step(1'b1);
      guard++;
    end
    chk("reach_lockout6", int'(guard < 200), 1);
    chk("lockout6_overheated", int'(overheated), 1);
    shoot = 1'b1;
    do_reset();
    step(1'b1);
    chk("post_reset_first_pulse", int'(fire_pulse), 1);
    chk("post_reset_heat", int'(heat), 1);

    // Random phases with varying fire density and occasional resets.
    for (int ph = 0; ph < 8; ph++) begin
      p = $urandom_range(0, 100);
      for (int c = 0; c < 60; c++) begin
        if ($urandom_range(0, 199) == 0) do_reset();
        step($urandom_range(0, 99) < p);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
